nfca_rx_window_ctrl: RTL and testbench

//  Sequences the PICC->PCD receive window of the NFC-A controller.
//  - After each PCD frame ends, waits a guard time, then drives rx_on/remainb into the bit->byte RX parser.
//  - Enforces a response timeout, collects parsed bytes into a show-ahead FIFO for the host/uart side,
//    and reports a per-frame completion status (OK / COLL / ERR / TIMEOUT).

---
 rtl/nfca_rx_window_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_nfca_rx_window_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nfca_rx_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nfca_rx_window_ctrl
// Purpose  : NFC-A PICC->PCD receive window sequencer. Waits a guard time after
//            each PCD frame, enables the RX parser, enforces response and
//            receive timeouts, and collects parsed bytes into a show-ahead FIFO.
//            Reports a per-frame status of OK, COLL, ERR or TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module nfca_rx_window_ctrl #(
  parameter int GUARD_CYC   = 1024,
  parameter int TIMEOUT_CYC = 65536,
  parameter int RXMAX_CYC   = 1048576,
  parameter int CNT_W       = 21,
  parameter int FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_end,
  input  logic [2:0] tx_remainb,
  input  logic       abort,
  output logic       rx_on,
  output logic [2:0] remainb,
  input  logic       rx_tvalid,
  input  logic [7:0] rx_tdata,
  input  logic [3:0] rx_tdatab,
  input  logic       rx_tend,
  input  logic       rx_terr,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic [3:0] m_tdatab,
  output logic       m_tlast,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] byte_count,
  output logic       overflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GUARD  = 3'd1;
  localparam logic [2:0] S_LISTEN = 3'd2;
  localparam logic [2:0] S_RECV   = 3'd3;
  localparam logic [2:0] S_CLOSE  = 3'd4;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_COLL = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  localparam logic [CNT_W-1:0]   GUARD_T = CNT_W'(GUARD_CYC);
  localparam logic [CNT_W-1:0]   TMO_T   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   RXMAX_T = CNT_W'(RXMAX_CYC);
  localparam int                 DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   ONE_C   = (FIFO_AW + 1)'(1);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [2:0]         remainb_q, remainb_d;
  logic [1:0]         status_q, status_d;
  logic [7:0]         bcnt_q, bcnt_d;
  logic               ovf_q, ovf_d;
  logic               partial_q, partial_d;
  logic               pend_v_q, pend_v_d;
  logic [11:0]        pend_q, pend_d;

  logic [12:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0]   cnt_q;

  logic               w_accept, w_flush, w_rxmax, w_beat, w_has_byte, w_ovf_now;
  logic               w_push0, w_push1, w_pop, w_acc0, w_acc1, w_drop;
  logic [12:0]        w_d0, w_d1;
  logic [11:0]        w_new;
  logic [FIFO_AW:0]   w_free;
  logic [1:0]         w_nstore;
  logic [8:0]         w_bsum;

  // A tx_end is only taken from IDLE, and abort always overrides it.
  assign w_accept   = (state_q == S_IDLE) && tx_end && !abort;
  assign w_flush    = abort || w_accept;
  // The receive-length limit closes the frame; a beat landing on that cycle is dropped.
  assign w_rxmax    = (state_q == S_RECV) && (timer_q == RXMAX_T);
  assign w_beat     = rx_tvalid && !abort &&
                      ((state_q == S_LISTEN) || ((state_q == S_RECV) && !w_rxmax));
  assign w_has_byte = (rx_tdatab != 4'd0);
  assign w_new      = {rx_tdatab, rx_tdata};

  // Up to two FIFO writes per cycle: the older pending byte, then the closing byte.
  always_comb begin
    w_push0 = 1'b0;
    w_push1 = 1'b0;
    w_d0    = '0;
    w_d1    = '0;
    if (w_beat) begin
      if (w_has_byte) begin
        if (pend_v_q) begin
          w_push0 = 1'b1;
          w_d0    = {1'b0, pend_q};
          if (rx_tend) begin
            w_push1 = 1'b1;
            w_d1    = {1'b1, w_new};
          end
        end else if (rx_tend) begin
          w_push0 = 1'b1;
          w_d0    = {1'b1, w_new};
        end
      end else if (rx_tend && pend_v_q) begin
        w_push0 = 1'b1;
        w_d0    = {1'b1, pend_q};
      end
    end else if (w_rxmax && !abort && pend_v_q) begin
      w_push0 = 1'b1;
      w_d0    = {1'b1, pend_q};
    end
  end

  // A pop that happens this cycle frees a slot for a same-cycle push.
  assign w_pop     = (cnt_q != '0) && m_tready && !w_flush;
  assign w_free    = DEPTH_C - cnt_q;
  assign w_acc0    = w_push0 && ((w_free != '0) || w_pop);
  assign w_acc1    = w_push1 && ((w_free > ONE_C) || ((w_free == ONE_C) && w_pop));
  assign w_drop    = (w_push0 && !w_acc0) || (w_push1 && !w_acc1);
  assign w_nstore  = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_ovf_now = ovf_q || w_drop;
  assign w_bsum    = {1'b0, bcnt_q} + {7'd0, w_nstore};

  // Window sequencing, beat bookkeeping and frame result.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + CNT_W'(1);
    remainb_d = remainb_q;
    status_d  = status_q;
    partial_d = partial_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    bcnt_d    = w_bsum[8] ? 8'hFF : w_bsum[7:0];
    ovf_d     = w_ovf_now;

    if (w_beat) begin
      if (w_has_byte && !rx_tend) begin
        pend_d   = w_new;
        pend_v_d = 1'b1;
        if (rx_tdatab < 4'd8) partial_d = 1'b1;
      end
      if (rx_tend) pend_v_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        timer_d = timer_q;
        if (w_accept) begin
          state_d   = S_GUARD;
          timer_d   = '0;
          remainb_d = tx_remainb;
          status_d  = ST_OK;
          partial_d = 1'b0;
          pend_v_d  = 1'b0;
          bcnt_d    = 8'd0;
          ovf_d     = 1'b0;
        end
      end
      S_GUARD: begin
        if (timer_q == GUARD_T) begin
          state_d = S_LISTEN;
          timer_d = '0;
        end
      end
      S_LISTEN, S_RECV: begin
        if (w_beat && rx_tend) begin
          state_d  = S_CLOSE;
          status_d = (rx_terr || w_ovf_now) ? ST_ERR : (partial_q ? ST_COLL : ST_OK);
        end else if (w_beat && (state_q == S_LISTEN)) begin
          state_d = S_RECV;
          timer_d = '0;
        end else if ((state_q == S_LISTEN) && (timer_q == TMO_T)) begin
          state_d  = S_CLOSE;
          status_d = ST_TMO;
        end else if (w_rxmax) begin
          state_d  = S_CLOSE;
          status_d = ST_ERR;
          pend_v_d = 1'b0;
        end
      end
      S_CLOSE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      timer_d  = '0;
      pend_v_d = 1'b0;
      status_d = status_q;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      remainb_q <= 3'd0;
      status_q  <= ST_OK;
      bcnt_q    <= 8'd0;
      ovf_q     <= 1'b0;
      partial_q <= 1'b0;
      pend_v_q  <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      remainb_q <= remainb_d;
      status_q  <= status_d;
      bcnt_q    <= bcnt_d;
      ovf_q     <= ovf_d;
      partial_q <= partial_d;
      pend_v_q  <= pend_v_d;
      pend_q    <= pend_d;
    end
  end

  // FIFO pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (w_flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + FIFO_AW'(w_nstore);
      rd_q  <= rd_q + FIFO_AW'(w_pop);
      cnt_q <= cnt_q + (FIFO_AW + 1)'(w_nstore) - (FIFO_AW + 1)'(w_pop);
    end
  end

  // FIFO storage; entries are {last, tdatab, tdata}.
  always_ff @(posedge clk) begin
    if (w_acc0) mem_q[wr_q] <= w_d0;
    if (w_acc1) mem_q[wr_q + FIFO_AW'(1)] <= w_d1;
  end

  assign rx_on      = (state_q == S_LISTEN) || (state_q == S_RECV);
  assign remainb    = remainb_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_CLOSE);
  assign status     = status_q;
  assign byte_count = bcnt_q;
  assign overflow   = ovf_q;
  assign m_tvalid   = (cnt_q != '0);
  assign {m_tlast, m_tdatab, m_tdata} = mem_q[rd_q];

endmodule
`default_nettype wire

// File: tb/tb_nfca_rx_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nfca_rx_window_ctrl
// Purpose  : Directed self-checking bench for nfca_rx_window_ctrl with an
//            expected-FIFO-content scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nfca_rx_window_ctrl;

  localparam int GUARD = 8;
  localparam int TMO   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_end = 1'b0;
  logic [2:0] tx_remainb = 3'd0;
  logic       abort = 1'b0;
  logic       rx_on;
  logic [2:0] remainb;
  logic       rx_tvalid = 1'b0;
  logic [7:0] rx_tdata = 8'd0;
  logic [3:0] rx_tdatab = 4'd0;
  logic       rx_tend = 1'b0;
  logic       rx_terr = 1'b0;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic [3:0] m_tdatab;
  logic       m_tlast;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [7:0] byte_count;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [12:0] exp_q[$];
  logic        mp_v = 1'b0;
  logic [11:0] mp = '0;

  nfca_rx_window_ctrl #(
    .GUARD_CYC  (GUARD),
    .TIMEOUT_CYC(TMO),
    .RXMAX_CYC  (64),
    .CNT_W      (8),
    .FIFO_AW    (2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tx_end    (tx_end),
    .tx_remainb(tx_remainb),
    .abort     (abort),
    .rx_on     (rx_on),
    .remainb   (remainb),
    .rx_tvalid (rx_tvalid),
    .rx_tdata  (rx_tdata),
    .rx_tdatab (rx_tdatab),
    .rx_tend   (rx_tend),
    .rx_terr   (rx_terr),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tdatab  (m_tdatab),
    .m_tlast   (m_tlast),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .byte_count(byte_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard push: the consumer is stalled during frames, so space is DEPTH.
  task automatic model_push(input logic [12:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
  endtask

  task automatic model_clear();
    exp_q.delete();
    mp_v = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after rx_on should have risen.
  task automatic start_frame(input logic [2:0] rb);
    tx_remainb = rb;
    tx_end = 1'b1;
    @(negedge clk);
    tx_end = 1'b0;
    model_clear();
    repeat (GUARD) @(negedge clk);
    check("guard_rx_off", rx_on, 0);
    @(negedge clk);
    check("guard_rx_on", rx_on, 1);
    check("remainb", remainb, rb);
    check("status_cleared", status, 0);
    check("ovf_cleared", overflow, 0);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [3:0] b, input logic te, input logic er);
    rx_tvalid = 1'b1; rx_tdata = d; rx_tdatab = b; rx_tend = te; rx_terr = er;
    if (b != 4'd0) begin
      if (mp_v) model_push({1'b0, mp});
      if (te) begin
        model_push({1'b1, b, d});
        mp_v = 1'b0;
      end else begin
        mp = {b, d};
        mp_v = 1'b1;
      end
    end else if (te && mp_v) begin
      model_push({1'b1, mp});
      mp_v = 1'b0;
    end
    @(negedge clk);
    rx_tvalid = 1'b0; rx_tdata = 8'd0; rx_tdatab = 4'd0; rx_tend = 1'b0; rx_terr = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [1:0] st, input logic [7:0] bc, input logic ov);
    check({tag, "_done"}, done, 1);
    check({tag, "_rx_off"}, rx_on, 0);
    check({tag, "_status"}, status, st);
    check({tag, "_bcount"}, byte_count, bc);
    check({tag, "_ovf"}, overflow, ov);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  // Pop every DUT entry, comparing each against the scoreboard head.
  task automatic drain(input string tag);
    int n_exp;
    int n_got;
    logic [12:0] e;
    n_exp = exp_q.size();
    n_got = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!m_tvalid || exp_q.size() == 0) break;
      e = exp_q.pop_front();
      check({tag, "_head"}, {m_tlast, m_tdatab, m_tdata}, e);
      n_got++;
      @(negedge clk);
    end
    m_tready = 1'b0;
    check({tag, "_popped"}, n_got, n_exp);
    check({tag, "_empty"}, m_tvalid, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rx_on", rx_on, 0);
    check("rst_remainb", remainb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_bcount", byte_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_mtvalid", m_tvalid, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Guard timing and plain two-byte frame
    start_frame(3'd3);
    send_beat(8'h93, 4'd8, 1'b0, 1'b0);
    send_beat(8'h70, 4'd8, 1'b0, 1'b0);
    send_beat(8'h00, 4'd0, 1'b1, 1'b0);
    check_done("ok2", 2'd0, 8'd2, 1'b0);
    drain("ok2");

    // Collision frame; a tx_end inside the window must be ignored
    start_frame(3'd5);
    tx_end = 1'b1;
    @(negedge clk);
    tx_end = 1'b0;
    check("txend_ignored", rx_on, 1);
    send_beat(8'h05, 4'd3, 1'b0, 1'b0);
    send_beat(8'h00, 4'd0, 1'b1, 1'b0);
    check_done("coll", 2'd1, 8'd1, 1'b0);
    drain("coll");

    // Response timeout
    start_frame(3'd0);
    repeat (TMO) @(negedge clk);
    check("tmo_still_on", rx_on, 1);
    @(negedge clk);
    check_done("tmo", 2'd3, 8'd0, 1'b0);
    check("tmo_fifo_empty", m_tvalid, 0);

    // FIFO overflow with stalled consumer
    start_frame(3'd0);
    for (int i = 0; i < 6; i++) send_beat(8'h10 + 8'(i), 4'd8, 1'b0, 1'b0);
    send_beat(8'h00, 4'd0, 1'b1, 1'b0);
    check_done("ovf", 2'd2, 8'd4, 1'b1);
    drain("ovf");

    // Abort in RECV, then a normal frame closing with a two-byte beat
    start_frame(3'd1);
    send_beat(8'h21, 4'd8, 1'b0, 1'b0);
    send_beat(8'h22, 4'd8, 1'b0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    model_clear();
    check("abort_rx_off", rx_on, 0);
    check("abort_idle", busy, 0);
    check("abort_no_done", done, 0);
    check("abort_flushed", m_tvalid, 0);
    @(negedge clk);
    check("abort_no_done2", done, 0);
    start_frame(3'd2);
    send_beat(8'hA5, 4'd8, 1'b0, 1'b0);
    send_beat(8'h5A, 4'd4, 1'b1, 1'b0);
    check_done("post_abort", 2'd0, 8'd2, 1'b0);
    drain("post_abort");

    // Parser error on a single-byte frame
    start_frame(3'd0);
    send_beat(8'h3C, 4'd8, 1'b1, 1'b1);
    check_done("terr", 2'd2, 8'd1, 1'b0);
    drain("terr");

    // Asynchronous reset mid-frame
    start_frame(3'd4);
    send_beat(8'h77, 4'd8, 1'b0, 1'b0);
    send_beat(8'h78, 4'd8, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    check("arst_rx_off", rx_on, 0);
    check("arst_busy", busy, 0);
    check("arst_fifo", m_tvalid, 0);
    check("arst_remainb", remainb, 0);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
